// File: rtl/serial_demux_pkg.sv
// Shared types and helpers for the serial 1:N demultiplexer.
// Optional parity support in the demux is enabled by defining SERIAL_DEMUX_PARITY_EN.
package serial_demux_pkg;

    localparam int WORD_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2
    } state_t;

    // Bit that makes the word plus itself XOR to zero.
    function automatic logic even_parity(input logic [31:0] i_word);
        return ^i_word;
    endfunction

endpackage

// File: rtl/serial_demux_8_lane_decoder.sv
// One-hot lane write-enable decoder: lane i is enabled when i_en is high and i_idx == i.
module lane_decoder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_we
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        assign o_we[gi] = i_en && (i_idx == IDX_W'(gi));
    end

endmodule

// File: rtl/serial_demux_8.sv
// Sequential 1:WIDTH demultiplexer: assembles a serial bit stream into parallel words behind a
// valid/ready output register. Define SERIAL_DEMUX_PARITY_EN for a trailing even-parity bit per frame.
module serial_demux_8
    import serial_demux_pkg::*;
#(
    parameter int WIDTH = WORD_W_DEF,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [IDX_W-1:0] lane_sel,
    output logic             frame_abort,
    output logic             overrun,
    input  logic             ovr_clr
`ifdef SERIAL_DEMUX_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] w_shadow_next;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_dout_next;
    logic             r_dout_valid;
    logic             w_dout_valid_next;
    logic             r_frame_abort;
    logic             w_abort;
    logic             r_overrun;
    logic             w_overrun_next;
    logic             w_xfer;
    logic             w_load;
    logic             w_drop;
    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    logic [WIDTH-1:0] w_lane_we;
`ifdef SERIAL_DEMUX_PARITY_EN
    logic             r_parity_err;
    logic             w_parity_err_next;
    logic             w_xfer_perr;
`endif

    // A sync bit always lands in lane 0, whatever state the frame was in.
    assign w_wr_en  = din_valid && (sync || (r_state == COLLECT));
    assign w_wr_idx = sync ? '0 : r_idx;

    lane_decoder #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_lane_decoder (
        .i_idx (w_wr_idx),
        .i_en  (w_wr_en),
        .o_we  (w_lane_we)
    );

    // Unwritten lanes keep the previous frame's value.
    assign w_shadow_next = (r_shadow & ~w_lane_we) | ({WIDTH{din}} & w_lane_we);

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_xfer       = 1'b0;
        w_abort      = 1'b0;
`ifdef SERIAL_DEMUX_PARITY_EN
        w_xfer_perr  = 1'b0;
`endif
        if (din_valid && sync) begin
            w_state_next = COLLECT;
            w_idx_next   = IDX_W'(1);
            w_abort      = (r_state != IDLE);
        end else if (din_valid) begin
            case (r_state)
                COLLECT: begin
                    // Index wraps to 0 after the last lane, so IDLE/PARITY read lane 0.
                    w_idx_next = r_idx + IDX_W'(1);
                    if (r_idx == IDX_LAST) begin
`ifdef SERIAL_DEMUX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_xfer       = 1'b1;
                        w_state_next = IDLE;
`endif
                    end
                end
`ifdef SERIAL_DEMUX_PARITY_EN
                PARITY: begin
                    w_xfer       = 1'b1;
                    w_xfer_perr  = (even_parity(32'(r_shadow)) != din);
                    w_state_next = IDLE;
                    w_idx_next   = '0;
                end
`endif
                default: begin
                    w_state_next = IDLE;
                    w_idx_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_load = w_xfer && (!r_dout_valid || dout_ready);
        w_drop = w_xfer && !w_load;

        w_dout_next       = r_dout;
        w_dout_valid_next = r_dout_valid;
        if (w_load) begin
            w_dout_next       = w_shadow_next;
            w_dout_valid_next = 1'b1;
        end else if (r_dout_valid && dout_ready) begin
            w_dout_valid_next = 1'b0;
        end

        // A new drop outranks a clear arriving in the same cycle.
        w_overrun_next = r_overrun;
        if (w_drop) begin
            w_overrun_next = 1'b1;
        end else if (ovr_clr) begin
            w_overrun_next = 1'b0;
        end
`ifdef SERIAL_DEMUX_PARITY_EN
        w_parity_err_next = w_load ? w_xfer_perr : r_parity_err;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_shadow      <= '0;
            r_dout        <= '0;
            r_dout_valid  <= 1'b0;
            r_frame_abort <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_idx         <= w_idx_next;
            r_shadow      <= w_shadow_next;
            r_dout        <= w_dout_next;
            r_dout_valid  <= w_dout_valid_next;
            r_frame_abort <= w_abort;
            r_overrun     <= w_overrun_next;
        end
    end

`ifdef SERIAL_DEMUX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_parity_err_next;
        end
    end

    assign parity_err = r_parity_err;
`endif

    assign dout        = r_dout;
    assign dout_valid  = r_dout_valid;
    assign lane_sel    = r_idx;
    assign frame_abort = r_frame_abort;
    assign overrun     = r_overrun;

endmodule
